// File: rtl/button_write_ctrl_pkg.sv
// button_write_ctrl_pkg: shared constants, action encoding and counter sizing for the button write controller
package button_write_ctrl_pkg;

    localparam int NREG           = 8;
    localparam int MAX_DATO       = 9;
    localparam int DEB_CYCLES_SYN = 500000;
    localparam int DEB_CYCLES_SIM = 4;
    localparam int DEB_CNT_W      = $clog2(DEB_CYCLES_SYN);

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_WRITE,
        ACT_REJECT,
        ACT_CLEAR
    } wr_action_e;

    // Debounce counter width; never below one bit so tiny sim values still elaborate
    function automatic int deb_cnt_w(input int deb_cycles);
        return (deb_cycles > 1) ? $clog2(deb_cycles) : 1;
    endfunction

endpackage

// File: rtl/button_write_ctrl_if.sv
// button_write_ctrl_if: board-side buttons/switches and bank-side write port of the controller
interface button_write_ctrl_if #(
    parameter int BIT_ADDR = 4,
    parameter int BIT_DATO = 4
);
    logic                btn_wr_n;
    logic                btn_clr_n;
    logic [BIT_ADDR-1:0] sw_addr;
    logic [BIT_DATO-1:0] sw_dat;
    logic [BIT_ADDR-1:0] addrW;
    logic [BIT_DATO-1:0] datW;
    logic                RegWrite;
    logic                clr_n;
    logic                err;
    logic [7:0]          wr_cnt;

    modport master (
        input  btn_wr_n, btn_clr_n, sw_addr, sw_dat,
        output addrW, datW, RegWrite, clr_n, err, wr_cnt
    );

    modport slave (
        output btn_wr_n, btn_clr_n, sw_addr, sw_dat,
        input  addrW, datW, RegWrite, clr_n, err, wr_cnt
    );
endinterface

// File: rtl/button_write_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and one-cycle press pulse for an active-low button
module btn_debounce
    import button_write_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_SYN
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CW = deb_cnt_w(DEB_CYCLES);

    logic [1:0]    sync_q, sync_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          differ, flip;

    // Count while the synchronized level disagrees; flip the debounced level once it has held long enough
    always_comb begin
        sync_d  = {sync_q[0], btn_n};
        differ  = sync_q[1] != deb_q;
        flip    = differ && (cnt_q == CW'(DEB_CYCLES - 1));
        deb_d   = flip ? sync_q[1] : deb_q;
        cnt_d   = (differ && !flip) ? cnt_q + CW'(1) : '0;
        press_d = deb_q && !deb_d;
    end

    // State registers; reset treats the button as released with no partial count
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/button_write_ctrl.sv
// button_write_ctrl: debounced write/clear buttons driving the register bank write port with validation
module button_write_ctrl #(
    parameter int BIT_ADDR   = 4,
    parameter int BIT_DATO   = 4,
    parameter int NREG       = button_write_ctrl_pkg::NREG,
    parameter int MAX_DATO   = button_write_ctrl_pkg::MAX_DATO,
    parameter int DEB_CYCLES = button_write_ctrl_pkg::DEB_CYCLES_SYN
) (
    input logic                clk,
    input logic                rst,
    button_write_ctrl_if.master bus
);
    import button_write_ctrl_pkg::*;

    logic                press_wr, press_clr, valid;
    wr_action_e          act;
    logic [BIT_ADDR-1:0] addr_w_q, addr_w_d;
    logic [BIT_DATO-1:0] dat_w_q, dat_w_d;
    logic                reg_write_q, reg_write_d;
    logic                clr_n_q, clr_n_d;
    logic                err_q, err_d;
    logic [7:0]          wr_cnt_q, wr_cnt_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_wr (
        .clk   (clk),
        .rst   (rst),
        .btn_n (bus.btn_wr_n),
        .press (press_wr)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .btn_n (bus.btn_clr_n),
        .press (press_clr)
    );

    // Decide the action for this cycle (clear beats write) and the resulting output values
    always_comb begin
        valid       = (32'(bus.sw_addr) < NREG) && (32'(bus.sw_dat) <= MAX_DATO);
        act         = press_clr ? ACT_CLEAR : press_wr ? (valid ? ACT_WRITE : ACT_REJECT) : ACT_NONE;
        addr_w_d    = (act == ACT_WRITE) ? bus.sw_addr : addr_w_q;
        dat_w_d     = (act == ACT_WRITE) ? bus.sw_dat : dat_w_q;
        reg_write_d = act != ACT_WRITE;
        clr_n_d     = act != ACT_CLEAR;
        err_d       = (act == ACT_REJECT) ? 1'b1 : (act == ACT_NONE) ? err_q : 1'b0;
        wr_cnt_d    = (act == ACT_WRITE) ? wr_cnt_q + 8'd1 : wr_cnt_q;
    end

    // Output registers; addrW/datW only move together with a write strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_w_q    <= '0;
            dat_w_q     <= '0;
            reg_write_q <= 1'b1;
            clr_n_q     <= 1'b1;
            err_q       <= 1'b0;
            wr_cnt_q    <= '0;
        end else begin
            addr_w_q    <= addr_w_d;
            dat_w_q     <= dat_w_d;
            reg_write_q <= reg_write_d;
            clr_n_q     <= clr_n_d;
            err_q       <= err_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign bus.addrW    = addr_w_q;
    assign bus.datW     = dat_w_q;
    assign bus.RegWrite = reg_write_q;
    assign bus.clr_n    = clr_n_q;
    assign bus.err      = err_q;
    assign bus.wr_cnt   = wr_cnt_q;
endmodule

// File: tb/tb_button_write_ctrl.sv
// tb_button_write_ctrl: directed scoreboard bench for button_write_ctrl with DEB_CYCLES=4
module tb_button_write_ctrl;
    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    typedef struct {
        int         cyc;
        logic       rw;
        logic       cn;
        logic [3:0] a;
        logic [3:0] d;
        logic [7:0] cnt;
        logic       e;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];

    logic [3:0] m_addr = '0;
    logic [3:0] m_dat = '0;
    logic [7:0] m_cnt = '0;
    logic       m_err = 1'b0;

    button_write_ctrl_if #(.BIT_ADDR(4), .BIT_DATO(4)) bus ();

    button_write_ctrl #(
        .BIT_ADDR   (4),
        .BIT_DATO   (4),
        .NREG       (8),
        .MAX_DATO   (9),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe cycle seen on the bank side
    always @(negedge clk) begin
        if (bus.RegWrite === 1'b0 || bus.clr_n === 1'b0)
            obs_q.push_back('{cyc, bus.RegWrite, bus.clr_n, bus.addrW, bus.datW, bus.wr_cnt, bus.err});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press one or both buttons, predict the resulting strobe, wiggle switches while held, then release
    task automatic press(input bit wr, input bit clr, input logic [3:0] a, input logic [3:0] d);
        int t0;
        bus.sw_addr = a;
        bus.sw_dat  = d;
        if (wr) bus.btn_wr_n = 1'b0;
        if (clr) bus.btn_clr_n = 1'b0;
        t0 = cyc;
        if (clr) begin
            m_err = 1'b0;
            exp_q.push_back('{t0 + LAT, 1'b1, 1'b0, m_addr, m_dat, m_cnt, 1'b0});
        end else if (a < 4'd8 && d <= 4'd9) begin
            m_addr = a;
            m_dat  = d;
            m_cnt  = m_cnt + 8'd1;
            m_err  = 1'b0;
            exp_q.push_back('{t0 + LAT, 1'b0, 1'b1, m_addr, m_dat, m_cnt, 1'b0});
        end else begin
            m_err = 1'b1;
        end
        tick(LAT + 2);
        bus.sw_addr = 4'hf;
        bus.sw_dat  = 4'hf;
        tick(6);
        bus.btn_wr_n  = 1'b1;
        bus.btn_clr_n = 1'b1;
        tick(LAT + 2);
    endtask

    // Pair predicted strobes with observed ones, then require nothing left over
    task automatic drain(input string tag);
        ev_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk({tag, " missing strobe"}, 0, 1);
            end else begin
                o = obs_q.pop_front();
                chk({tag, " cycle"}, o.cyc, e.cyc);
                chk({tag, " RegWrite"}, o.rw, e.rw);
                chk({tag, " clr_n"}, o.cn, e.cn);
                chk({tag, " addrW"}, o.a, e.a);
                chk({tag, " datW"}, o.d, e.d);
                chk({tag, " wr_cnt"}, o.cnt, e.cnt);
                chk({tag, " err"}, o.e, e.e);
            end
        end
        chk({tag, " extra strobes"}, obs_q.size(), 0);
        obs_q.delete();
        chk({tag, " err level"}, bus.err, m_err);
        chk({tag, " wr_cnt level"}, bus.wr_cnt, m_cnt);
    endtask

    initial begin
        int rr, n;
        bus.btn_wr_n  = 1'b1;
        bus.btn_clr_n = 1'b1;
        bus.sw_addr   = '0;
        bus.sw_dat    = '0;
        tick(3);
        chk("reset RegWrite", bus.RegWrite, 1'b1);
        chk("reset clr_n", bus.clr_n, 1'b1);
        chk("reset addrW", bus.addrW, 4'd0);
        chk("reset datW", bus.datW, 4'd0);
        chk("reset err", bus.err, 1'b0);
        chk("reset wr_cnt", bus.wr_cnt, 8'd0);
        rst = 1'b1;
        tick(3);
        obs_q.delete();

        press(1, 0, 4'd3, 4'd7);
        drain("valid write");

        for (int i = 0; i < 10; i++) begin
            bus.btn_wr_n = i[0];
            tick(2);
        end
        chk("bounce no strobe", obs_q.size(), 0);
        press(1, 0, 4'd5, 4'd2);
        drain("bounced write");

        press(1, 0, 4'd4, 4'd10);
        drain("bad data");
        press(1, 0, 4'd8, 4'd1);
        drain("bad addr");
        press(1, 0, 4'd2, 4'd9);
        drain("recover write");

        press(1, 0, 4'd1, 4'd12);
        press(1, 1, 4'd6, 4'd6);
        drain("simultaneous");

        n = 256 - int'(m_cnt);
        for (int i = 0; i < n; i++)
            press(1, 0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 9)));
        drain("wrap run");
        chk("wrap to zero", bus.wr_cnt, 8'd0);

        bus.sw_addr  = 4'd6;
        bus.sw_dat   = 4'd4;
        bus.btn_wr_n = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(1);
        rr  = cyc;
        rst = 1'b1;
        chk("rst wr_cnt", bus.wr_cnt, 8'd0);
        chk("rst addrW", bus.addrW, 4'd0);
        m_addr = 4'd6;
        m_dat  = 4'd4;
        m_cnt  = 8'd1;
        m_err  = 1'b0;
        exp_q.push_back('{rr + LAT, 1'b0, 1'b1, 4'd6, 4'd4, 8'd1, 1'b0});
        tick(LAT + 8);
        bus.btn_wr_n = 1'b1;
        tick(LAT + 2);
        drain("mid-debounce reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/button_write_ctrl.md
Name: button_write_ctrl

Overview:
- Input stage directly upstream of the register bank. Takes the raw active-low write and clear push-buttons plus the address/data slide switches from the board.
- Debounces both buttons and validates the switch values.
- Drives the bank's write port (addrW, datW, RegWrite) and its clear input, each as a single-cycle active-low strobe per physical press.
- Reports rejected entries on an error LED and counts accepted writes.

Parameters:
- BIT_ADDR, 4, address width; must match the bank.
- BIT_DATO, 4, data width; must match the bank.
- NREG, 8, number of implemented bank registers. Addresses >= NREG are rejected.
- MAX_DATO, 9, largest accepted data value (BCD digit).
- DEB_CYCLES, 500000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz). Simulation uses 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- btn_wr_n  in  1  raw write button, active-low, asynchronous, bouncy.
- btn_clr_n  in  1  raw clear button, active-low, asynchronous, bouncy.
- sw_addr  in  BIT_ADDR  address switches.
- sw_dat  in  BIT_DATO  data switches.
- addrW  out  BIT_ADDR  registered write address to the bank.
- datW  out  BIT_DATO  registered write data to the bank.
- RegWrite  out  1  write strobe to the bank, active-low, one cycle.
- clr_n  out  1  clear strobe to the bank's rst, active-low, one cycle.
- err  out  1  sticky flag: last write attempt was rejected.
- wr_cnt  out  8  count of accepted writes.

Behaviour:
- Reset (rst=0 at a clk edge): RegWrite=1, clr_n=1, addrW=0, datW=0, err=0, wr_cnt=0.
  - Both debounced levels are forced to 1 (released); synchronizers are loaded with 1; debounce counters are 0.
  - Reset overrides every other action in the same cycle.
- Synchronizer: a 2-FF chain per button.
- Debouncer, per button:
  - Counter increments each cycle while the synchronized level differs from the debounced level.
  - Counter returns to 0 on any cycle where they are equal (a bounce restarts the count).
  - On the edge where the counter equals DEB_CYCLES-1 and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - A registered edge detector raises press=1 for exactly one cycle after the debounced level goes 1->0. Release generates nothing.
- Latency: from the raw button going low and staying low, the output strobe asserts exactly DEB_CYCLES+3 cycles later. That is 2 cycles of sync, DEB_CYCLES-1 cycles of counting to the flip, 1 cycle of edge detect, and 1 cycle of output register.
- Write press, on the cycle press_wr=1, with switches sampled in that cycle:
  - Valid (sw_addr < NREG and sw_dat <= MAX_DATO): next cycle addrW=sw_addr, datW=sw_dat, RegWrite=0, err=0, wr_cnt+1. The count wraps 255->0.
  - Invalid: RegWrite stays 1, err=1, addrW/datW/wr_cnt unchanged.
- Clear press: next cycle clr_n=0 for one cycle and err=0; wr_cnt is unchanged.
- Simultaneous press_wr and press_clr in the same cycle: clear wins, the write is dropped, and err and wr_cnt are unchanged apart from err->0.
- addrW/datW hold their last accepted value between strobes, so the bank never sees them change while RegWrite=0.
- A held button produces exactly one strobe. A new strobe requires a debounced release followed by a new debounced press.
- Switch changes while a button is held have no effect.
- Reset asserted mid-debounce discards the partial count. A button held through reset release is seen as a new press after the full debounce latency.

Decomposition:
- Shared package holds:
  - constants NREG, MAX_DATO, DEB_CYCLES_SYN = 500000, DEB_CYCLES_SIM = 4;
  - the counter width, defined as clog2(DEB_CYCLES).
- One sub-module, btn_debounce: 2-FF sync, counter, debounced level, one-cycle press pulse. It is instantiated twice.
- The top level holds validation, the output registers, err and wr_cnt.

Test Plan (DEB_CYCLES=4):
- Reset with both buttons released -> RegWrite=1, clr_n=1, addrW=0, datW=0, err=0, wr_cnt=0.
- sw_addr=3, sw_dat=7, btn_wr_n held low -> RegWrite=0 for exactly one cycle, 7 cycles after the fall, with addrW=3, datW=7, wr_cnt=1; no second strobe while held.
- btn_wr_n toggling every 2 cycles for 20 cycles, then held low -> no strobe during bouncing; one strobe 7 cycles after the final fall.
- sw_dat=10 (or sw_addr=8), press write -> RegWrite stays 1, err=1, wr_cnt unchanged; a next valid press (sw_dat=9) clears err and strobes.
- Both buttons fall in the same cycle -> clr_n=0 for one cycle, no RegWrite strobe, err=0.
- 256 valid presses -> wr_cnt wraps to 0. rst=0 pulsed mid-debounce -> no strobe until a full new debounce completes.
